// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: operand side (in_*) and result side (out_*).
interface alu_seq_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] ALU_Result;
  logic [3:0]   flags;

  modport master (
    output in_valid, A, B, opcode, out_ready,
    input  in_ready, out_valid, ALU_Result, flags
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready,
    output in_ready, out_valid, ALU_Result, flags
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential N-bit ALU with valid/ready handshakes, iterative rotate/popcount and {C,V,Neg,Z} flags.
// Optional macro ALU_SAT_EN: signed saturation for add/sub and abs of the most negative value.
module alu_seq #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] MAX_S = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_S = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] N_VAL = N'(N);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    res_q, res_d;
  logic [2:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      flags_q, flags_d;

  logic [N:0]      sum_w, diff_w;
  logic            add_ovf, sub_ovf, abs_ovf;
  logic [N-1:0]    rot_amt;
  logic            multi_w;
  logic [N-1:0]    imm_res;
  logic            imm_c, imm_v;
  logic [N-1:0]    rot_w, pop_w, step_res;

  // Single-cycle results come straight from the bus so they land in res_q on the accept edge.
  assign sum_w   = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_w  = {1'b0, bus.A} - {1'b0, bus.B};
  assign add_ovf = (bus.A[N-1] == bus.B[N-1]) && (sum_w[N-1]  != bus.A[N-1]);
  assign sub_ovf = (bus.A[N-1] != bus.B[N-1]) && (diff_w[N-1] != bus.A[N-1]);
  assign abs_ovf = (bus.B == MIN_S);
  assign rot_amt = bus.B % N_VAL;
  assign multi_w = (bus.opcode == 3'd6) || ((bus.opcode == 3'd5) && (rot_amt != '0));

  always_comb begin
    imm_res = '0;
    imm_c   = 1'b0;
    imm_v   = 1'b0;
    case (bus.opcode)
      3'd0: begin
        imm_res = sum_w[N-1:0];
        imm_c   = sum_w[N];
        imm_v   = add_ovf;
`ifdef ALU_SAT_EN
        if (add_ovf) imm_res = bus.A[N-1] ? MIN_S : MAX_S;
`endif
      end
      3'd1: begin
        imm_res = diff_w[N-1:0];
        imm_c   = diff_w[N];
        imm_v   = sub_ovf;
`ifdef ALU_SAT_EN
        if (sub_ovf) imm_res = bus.A[N-1] ? MIN_S : MAX_S;
`endif
      end
      3'd2: imm_res = bus.A & bus.B;
      3'd3: imm_res = ~(bus.A | bus.B);
      3'd4: imm_res = bus.A ^ bus.B;
      3'd5: imm_res = bus.A;
      3'd7: begin
        imm_res = bus.B[N-1] ? (~bus.B + N'(1)) : bus.B;
        imm_v   = abs_ovf;
`ifdef ALU_SAT_EN
        if (abs_ovf) imm_res = MAX_S;
`endif
      end
      default: imm_res = '0;
    endcase
  end

  assign rot_w    = {a_q[0], a_q[N-1:1]};
  assign pop_w    = acc_q + N'(a_q[0]) + N'(b_q[0]);
  assign step_res = (op_q == 3'd5) ? rot_w : pop_w;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d  = bus.A;
          b_d  = bus.B;
          op_d = bus.opcode;
          if (multi_w) begin
            acc_d   = '0;
            cnt_d   = (bus.opcode == 3'd6) ? CW'(N) : CW'(rot_amt);
            state_d = EXEC;
          end else begin
            res_d   = imm_res;
            flags_d = {imm_c, imm_v, imm_res[N-1], imm_res == '0};
            state_d = DONE;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == 3'd5) begin
          a_d = rot_w;
        end else begin
          acc_d = pop_w;
          a_d   = a_q >> 1;
          b_d   = b_q >> 1;
        end
        if (cnt_q == CW'(1)) begin
          res_d   = step_res;
          flags_d = {2'b00, step_res[N-1], step_res == '0};
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.ALU_Result = res_q;
  assign bus.flags      = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (N=8): driver pushes expected results, a negedge monitor pops and checks.
module tb_alu_seq;
  typedef struct {
    string      name;
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
    int         acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   seen = 1'b0;
  logic [7:0] held_res;
  logic [3:0] held_flg;

  alu_seq_if #(.N(8)) bus_if ();
  alu_seq #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: first cycle of out_valid pops one expectation; later cycles check the result is held.
  always @(negedge clk) begin
    if (!rst && bus_if.out_valid) begin
      if (!seen) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got result=%h flags=%b, required no output", bus_if.ALU_Result, bus_if.flags);
        end else begin
          mon_e = sb_q.pop_front();
          checks += 2;
          $display("txn %s: result=%h flags=%b latency=%0d", mon_e.name, bus_if.ALU_Result, bus_if.flags, cyc - mon_e.acc_cyc + 1);
          if (bus_if.ALU_Result !== mon_e.res) begin
            errors++;
            $display("FAIL %s_result: got %h required %h", mon_e.name, bus_if.ALU_Result, mon_e.res);
          end
          if (bus_if.flags !== mon_e.flg) begin
            errors++;
            $display("FAIL %s_flags: got %b required %b", mon_e.name, bus_if.flags, mon_e.flg);
          end
          if (cyc - mon_e.acc_cyc + 1 != mon_e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", mon_e.name, cyc - mon_e.acc_cyc + 1, mon_e.lat);
          end
        end
        held_res = bus_if.ALU_Result;
        held_flg = bus_if.flags;
        seen = 1'b1;
      end else begin
        checks++;
        if (bus_if.ALU_Result !== held_res || bus_if.flags !== held_flg) begin
          errors++;
          $display("FAIL hold_stable: got %h/%b required %h/%b", bus_if.ALU_Result, bus_if.flags, held_res, held_flg);
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  task automatic issue(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] er, input logic [3:0] ef, input int el, input bit track);
    int w = 0;
    @(negedge clk);
    while (!bus_if.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus_if.in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got in_ready=0 required 1", nm);
      return;
    end
    bus_if.in_valid = 1'b1;
    bus_if.A        = a;
    bus_if.B        = b;
    bus_if.opcode   = op;
    @(posedge clk);
    #1;
    if (track) sb_q.push_back('{name: nm, res: er, flg: ef, lat: el, acc_cyc: cyc});
    bus_if.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int w = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || bus_if.out_valid) && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (sb_q.size() != 0 || bus_if.out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got pending=%0d required 0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    logic [7:0] sat_add_r, sat_sub_r, sat_abs_r;
    logic [3:0] sat_add_f, sat_sub_f, sat_abs_f;
    int w;
`ifdef ALU_SAT_EN
    sat_add_r = 8'h7F; sat_add_f = 4'b0100;
    sat_sub_r = 8'h80; sat_sub_f = 4'b0110;
    sat_abs_r = 8'h7F; sat_abs_f = 4'b0100;
`else
    sat_add_r = 8'h80; sat_add_f = 4'b0110;
    sat_sub_r = 8'h7F; sat_sub_f = 4'b0100;
    sat_abs_r = 8'h80; sat_abs_f = 4'b0110;
`endif
    bus_if.in_valid  = 1'b1;
    bus_if.A         = 8'h12;
    bus_if.B         = 8'h34;
    bus_if.opcode    = 3'd0;
    bus_if.out_ready = 1'b1;

    // Reset state, with in_valid asserted to show no accept happens under reset.
    repeat (3) @(negedge clk);
    check("rst_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
    check("rst_result", bus_if.ALU_Result, 8'h00);
    check("rst_flags", {4'd0, bus_if.flags}, 8'h00);
    check("rst_in_ready", {7'd0, bus_if.in_ready}, 8'h01);
    bus_if.in_valid = 1'b0;
    rst = 1'b0;

    issue("add_ovf", 3'd0, 8'h7F, 8'h01, sat_add_r, sat_add_f, 1, 1'b1);
    drain("add_ovf");
    issue("add_carry", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1001, 1, 1'b1);
    drain("add_carry");
    issue("sub_borrow", 3'd1, 8'h05, 8'h07, 8'hFE, 4'b1010, 1, 1'b1);
    drain("sub_borrow");
    issue("sub_zero", 3'd1, 8'h3C, 8'h3C, 8'h00, 4'b0001, 1, 1'b1);
    drain("sub_zero");
    issue("and", 3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 1'b1);
    drain("and");
    issue("nor", 3'd3, 8'hF0, 8'h0C, 8'h03, 4'b0000, 1, 1'b1);
    drain("nor");
    issue("xor", 3'd4, 8'hAA, 8'hAA, 8'h00, 4'b0001, 1, 1'b1);
    drain("xor");
    issue("rot3", 3'd5, 8'h81, 8'h0B, 8'h30, 4'b0000, 4, 1'b1);
    drain("rot3");
    issue("rot8", 3'd5, 8'h81, 8'h08, 8'h81, 4'b0010, 1, 1'b1);
    drain("rot8");
    issue("rot7", 3'd5, 8'h01, 8'h07, 8'h02, 4'b0000, 8, 1'b1);
    drain("rot7");
    issue("pop", 3'd6, 8'hFF, 8'h0F, 8'h0C, 4'b0000, 9, 1'b1);
    drain("pop");
    issue("pop_zero", 3'd6, 8'h00, 8'h00, 8'h00, 4'b0001, 9, 1'b1);
    drain("pop_zero");
    issue("abs", 3'd7, 8'h00, 8'hF6, 8'h0A, 4'b0000, 1, 1'b1);
    drain("abs");
    issue("abs_min", 3'd7, 8'h00, 8'h80, sat_abs_r, sat_abs_f, 1, 1'b1);
    drain("abs_min");

    // Backpressure: result must hold and no accept may occur while out_ready is low.
    bus_if.out_ready = 1'b0;
    issue("sub_ovf_bp", 3'd1, 8'h80, 8'h01, sat_sub_r, sat_sub_f, 1, 1'b1);
    w = 0;
    while (!bus_if.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus_if.in_valid = ~bus_if.in_valid;
      bus_if.A        = 8'($urandom);
      bus_if.B        = 8'($urandom);
      check("bp_in_ready", {7'd0, bus_if.in_ready}, 8'h00);
      check("bp_out_valid", {7'd0, bus_if.out_valid}, 8'h01);
    end
    @(negedge clk);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", {7'd0, bus_if.in_ready}, 8'h01);
    check("bp_release_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
    drain("sub_ovf_bp");

    // Asynchronous reset in the middle of a popcount: the pending result is discarded.
    issue("pop_abort", 3'd6, 8'hFF, 8'h0F, 8'h0C, 4'b0000, 9, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {7'd0, bus_if.out_valid}, 8'h00);
    check("arst_result", bus_if.ALU_Result, 8'h00);
    check("arst_flags", {4'd0, bus_if.flags}, 8'h00);
    #1 rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready", {7'd0, bus_if.in_ready}, 8'h01);
    issue("add_after_rst", 3'd0, 8'h01, 8'h02, 8'h03, 4'b0000, 1, 1'b1);
    drain("add_after_rst");

    repeat (12) @(negedge clk);
    check("no_stray_output", {7'd0, bus_if.out_valid}, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
